icache_resp: RTL and testbench



---
 rtl/icache_resp.sv | 118 +++++++++++
 tb/tb_icache_resp.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_resp.sv
// Instruction-cache responder: forwards fetch addresses to memory and buffers returned
// words in a credit-limited FIFO; a flush empties the FIFO and drops in-flight returns.
module icache_resp #(
    parameter int DATA_W = 32,
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic              addr_valid_i,
    output logic              addr_ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // state | meaning
    // RUN   | normal operation, addresses forwarded while credit remains
    // FLUSH | waiting for pre-flush returns to drain; all returns discarded

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              valid;
    } icache_out_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] fifo_q [DEPTH];
    logic              credit_ok, accept, ret, push, pop;
    icache_out_t       out_s;

    // Credit uses registered occupancy only, so a pop this cycle frees nothing until next.
    assign credit_ok    = ({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_C;
    assign mem_req_o    = addr_valid_i && (state_q == RUN) && credit_ok && !flush_i && !rst_i;
    assign mem_addr_o   = addr_i;
    assign addr_ready_o = mem_req_o && mem_gnt_i;
    assign accept       = addr_ready_o;
    assign ret          = mem_rvalid_i && (outst_q != '0);

    assign out_s.data   = fifo_q[rd_ptr_q];
    assign out_s.valid  = (count_q != '0) && !rst_i;
    assign data_o       = out_s.data;
    assign data_valid_o = out_s.valid;
    assign pop          = out_s.valid && data_ready_i;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        drop_d  = drop_q;
        push    = 1'b0;
        outst_d = outst_q + CW'(accept) - CW'(ret);
        if (flush_i) begin
            // No accept is possible here, so everything still owed becomes drop.
            count_d = '0;
            drop_d  = outst_q - CW'(ret);
            state_d = (drop_d != '0) ? FLUSH : RUN;
        end else begin
            if (ret) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push = 1'b1;
                end
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if ((state_q == FLUSH) && (drop_d == '0)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= mem_rdata_i;
    end

    // A return with nothing outstanding is a memory-side protocol error.
    assert property (@(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && (outst_q == '0)));

endmodule

// File: tb/tb_icache_resp.sv
// Bench for icache_resp: DEPTH=2 and DEPTH=4 instances, each with a memory stub and a
// queue-level model of fetched words, checked every cycle plus directed literal checks.
module tb_icache_resp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       av, flush, dr, gnt, rv, ar, dv, mreq;
    logic [1:0][31:0] addr, rdata, dat, maddr;

    icache_resp #(.DATA_W(32), .XLEN(32), .DEPTH(2)) u_d2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .addr_i(addr[0]),
        .addr_valid_i(av[0]), .addr_ready_o(ar[0]), .data_o(dat[0]),
        .data_valid_o(dv[0]), .data_ready_i(dr[0]), .mem_req_o(mreq[0]),
        .mem_addr_o(maddr[0]), .mem_gnt_i(gnt[0]), .mem_rvalid_i(rv[0]),
        .mem_rdata_i(rdata[0])
    );

    icache_resp #(.DATA_W(32), .XLEN(32), .DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .addr_i(addr[1]),
        .addr_valid_i(av[1]), .addr_ready_o(ar[1]), .data_o(dat[1]),
        .data_valid_o(dv[1]), .data_ready_i(dr[1]), .mem_req_o(mreq[1]),
        .mem_addr_o(maddr[1]), .mem_gnt_i(gnt[1]), .mem_rvalid_i(rv[1]),
        .mem_rdata_i(rdata[1])
    );

    // Model: words waiting for the consumer, fetches in flight (with a discard mark),
    // and the memory stub's pending returns.
    logic [31:0] exp_w [2][16];
    int          exp_n [2];
    logic [31:0] inf_w [2][16];
    bit          inf_d [2][16];
    int          inf_n [2];
    int          mem_due [2][16];
    logic [31:0] mem_dat [2][16];
    int          mem_n [2];
    bit          p_req [2], p_ar [2], p_dv [2], s_grant [2];
    logic [31:0] s_maddr [2];
    int          cyc, lat, checks, errors;

    function automatic int depth_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (~a ^ 32'h0F0F_0000);
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, inst, cyc, act, want);
        end
    endtask

    task automatic cyc_begin();
        bit draining;
        for (int i = 0; i < 2; i++) begin
            rv[i]    = (mem_n[i] > 0) && (mem_due[i][0] == cyc);
            rdata[i] = rv[i] ? mem_dat[i][0] : 32'h0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            draining = 1'b0;
            for (int k = 0; k < inf_n[i]; k++) if (inf_d[i][k]) draining = 1'b1;
            p_req[i] = !rst && av[i] && !flush[i] && !draining && ((exp_n[i] + inf_n[i]) < depth_of(i));
            p_ar[i]  = p_req[i] && gnt[i];
            p_dv[i]  = !rst && (exp_n[i] > 0);
            chk("mem_req", i, 32'(mreq[i]), 32'(p_req[i]));
            chk("addr_ready", i, 32'(ar[i]), 32'(p_ar[i]));
            chk("data_valid", i, 32'(dv[i]), 32'(p_dv[i]));
            if (p_req[i]) chk("mem_addr", i, maddr[i], addr[i]);
            if (p_dv[i]) chk("data", i, dat[i], exp_w[i][0]);
            s_grant[i] = mreq[i] && gnt[i];
            s_maddr[i] = maddr[i];
        end
    endtask

    task automatic cyc_end();
        logic [31:0] w;
        bit          d;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                exp_n[i] = 0;
                inf_n[i] = 0;
                mem_n[i] = 0;
            end else begin
                if (rv[i]) begin
                    for (int k = 1; k < mem_n[i]; k++) begin
                        mem_due[i][k-1] = mem_due[i][k];
                        mem_dat[i][k-1] = mem_dat[i][k];
                    end
                    mem_n[i]--;
                end
                if (s_grant[i]) begin
                    mem_due[i][mem_n[i]] = cyc + lat;
                    mem_dat[i][mem_n[i]] = word_of(s_maddr[i]);
                    mem_n[i]++;
                end
                if (p_dv[i] && dr[i]) begin
                    for (int k = 1; k < exp_n[i]; k++) exp_w[i][k-1] = exp_w[i][k];
                    exp_n[i]--;
                end
                if (rv[i] && (inf_n[i] > 0)) begin
                    w = inf_w[i][0];
                    d = inf_d[i][0];
                    for (int k = 1; k < inf_n[i]; k++) begin
                        inf_w[i][k-1] = inf_w[i][k];
                        inf_d[i][k-1] = inf_d[i][k];
                    end
                    inf_n[i]--;
                    if (!d && !flush[i]) begin
                        exp_w[i][exp_n[i]] = w;
                        exp_n[i]++;
                    end
                end
                if (flush[i]) begin
                    exp_n[i] = 0;
                    for (int k = 0; k < inf_n[i]; k++) inf_d[i][k] = 1'b1;
                end
                if (p_ar[i]) begin
                    inf_w[i][inf_n[i]] = word_of(addr[i]);
                    inf_d[i][inf_n[i]] = 1'b0;
                    inf_n[i]++;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic quiet(input int n);
        av = '0; flush = '0; dr = '0; gnt = '0; addr = '0;
        for (int j = 0; j < n; j++) begin
            cyc_begin();
            cyc_end();
        end
    endtask

    initial begin
        int issued;
        bit newdone;
        checks = 0; errors = 0; cyc = 0; lat = 1;
        for (int i = 0; i < 2; i++) begin
            exp_n[i] = 0; inf_n[i] = 0; mem_n[i] = 0;
        end
        rst = 1'b1; av = '0; flush = '0; dr = '0; gnt = '0; addr = '0; rv = '0; rdata = '0;
        cyc_begin(); cyc_end();
        cyc_begin(); cyc_end();
        rst = 1'b0;

        // Idle after reset
        cyc_begin();
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, 32'(dv[i]), 32'd0);
            chk("rst_req", i, 32'(mreq[i]), 32'd0);
        end
        cyc_end();

        // Single fetch, latency 1
        lat = 1;
        av[0] = 1'b1; addr[0] = 32'h100; gnt[0] = 1'b1;
        cyc_begin(); chk("t1_accept", 0, 32'(ar[0]), 32'd1); cyc_end();
        av[0] = 1'b0;
        cyc_begin(); chk("t1_not_yet", 0, 32'(dv[0]), 32'd0); cyc_end();
        dr[0] = 1'b1;
        cyc_begin();
        chk("t1_valid", 0, 32'(dv[0]), 32'd1);
        chk("t1_data", 0, dat[0], 32'hDEAD_BEEF);
        cyc_end();
        cyc_begin(); chk("t1_empty", 0, 32'(dv[0]), 32'd0); cyc_end();
        quiet(2);

        // DEPTH=2 stalled consumer, third address held until the first pop
        lat = 1; issued = 0; gnt[0] = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            av[0]   = (issued < 3);
            addr[0] = 32'(32'h200 + 4 * issued);
            dr[0]   = (c >= 5);
            cyc_begin();
            if (c <= 1 || c == 6) chk("t2_accept", 0, 32'(ar[0]), 32'd1);
            if (c >= 2 && c <= 5) chk("t2_held", 0, 32'(ar[0]), 32'd0);
            if (c == 5) chk("t2_first", 0, dat[0], word_of(32'h200));
            if (c == 6) chk("t2_second", 0, dat[0], word_of(32'h204));
            if (c == 8) chk("t2_third", 0, dat[0], word_of(32'h208));
            if (ar[0]) issued++;
            cyc_end();
        end
        quiet(2);

        // DEPTH=4 streaming, one accept and one word per cycle
        lat = 1; issued = 0; gnt[1] = 1'b1; dr[1] = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            av[1]   = (issued < 8);
            addr[1] = 32'(32'h300 + 4 * issued);
            cyc_begin();
            if (c < 8) chk("t3_accept", 1, 32'(ar[1]), 32'd1);
            if (c >= 2 && c < 10) begin
                chk("t3_valid", 1, 32'(dv[1]), 32'd1);
                chk("t3_data", 1, dat[1], word_of(32'(32'h300 + 4 * (c - 2))));
            end
            if (ar[1]) issued++;
            cyc_end();
        end
        quiet(2);

        // Flush with one word buffered and two in flight
        lat = 4; newdone = 1'b0; gnt[1] = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            av[1]    = (c == 0 || c == 3 || c == 4) || (c >= 6 && !newdone);
            addr[1]  = (c == 0) ? 32'h400 : (c == 3) ? 32'h404 : (c == 4) ? 32'h408 : 32'h4F0;
            flush[1] = (c == 5);
            dr[1]    = (c >= 12);
            cyc_begin();
            if (c == 5) chk("t4_pre_valid", 1, 32'(dv[1]), 32'd1);
            if (c == 6) chk("t4_flushed", 1, 32'(dv[1]), 32'd0);
            if (c >= 6 && c <= 8) chk("t4_req_blocked", 1, 32'(mreq[1]), 32'd0);
            if (c == 9) chk("t4_resume", 1, 32'(ar[1]), 32'd1);
            if (c == 14) begin
                chk("t4_new_valid", 1, 32'(dv[1]), 32'd1);
                chk("t4_new_data", 1, dat[1], word_of(32'h4F0));
            end
            if (c >= 6 && ar[1]) newdone = 1'b1;
            cyc_end();
        end
        quiet(2);

        // Flush coinciding with a return and a granted address
        lat = 2; gnt[0] = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            av[0]    = (c == 0 || c == 2 || c == 3);
            addr[0]  = (c == 0) ? 32'h500 : 32'h504;
            flush[0] = (c == 2);
            dr[0]    = (c >= 6);
            cyc_begin();
            if (c == 2) begin
                chk("t5_no_accept", 0, 32'(ar[0]), 32'd0);
                chk("t5_no_req", 0, 32'(mreq[0]), 32'd0);
            end
            if (c >= 3 && c <= 5) chk("t5_no_valid", 0, 32'(dv[0]), 32'd0);
            if (c == 3) chk("t5_accept", 0, 32'(ar[0]), 32'd1);
            if (c == 6) begin
                chk("t5_valid", 0, 32'(dv[0]), 32'd1);
                chk("t5_data", 0, dat[0], word_of(32'h504));
            end
            cyc_end();
        end
        quiet(2);

        // Reset with two buffered and two in flight, then a fresh fetch
        lat = 5; gnt[1] = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            av[1]   = (c <= 3 || c == 7 || c == 9);
            addr[1] = (c <= 3) ? 32'(32'h600 + 4 * c) : 32'h700;
            rst     = (c == 7);
            dr[1]   = (c >= 9);
            if (c == 8) lat = 1;
            cyc_begin();
            if (c == 6) chk("t6_pre_valid", 1, 32'(dv[1]), 32'd1);
            if (c == 7) begin
                chk("t6_rst_req", 1, 32'(mreq[1]), 32'd0);
                chk("t6_rst_ready", 1, 32'(ar[1]), 32'd0);
                chk("t6_rst_valid", 1, 32'(dv[1]), 32'd0);
            end
            if (c == 8) begin
                chk("t6_idle_valid", 1, 32'(dv[1]), 32'd0);
                chk("t6_idle_req", 1, 32'(mreq[1]), 32'd0);
            end
            if (c == 9) chk("t6_accept", 1, 32'(ar[1]), 32'd1);
            if (c == 11) begin
                chk("t6_valid", 1, 32'(dv[1]), 32'd1);
                chk("t6_data", 1, dat[1], word_of(32'h700));
            end
            cyc_end();
        end
        rst = 1'b0;
        quiet(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
